// File: rtl/seg_display_if.sv
// Bundle of the decoded digit patterns, status levels and display drive
// outputs exchanged between the timer logic and the 7-segment multiplexer.
interface seg_display_if;
    logic [6:0] ones_segs;
    logic [6:0] tens_segs;
    logic [6:0] mins_segs;
    logic [6:0] min_tens_segs;
    logic       timer_done;
    logic       mag_on;
    logic [6:0] seg_out;
    logic [3:0] digit_en;
    logic       colon;
    logic       blinking;

    modport master (
        output ones_segs, tens_segs, mins_segs, min_tens_segs, timer_done, mag_on,
        input  seg_out, digit_en, colon, blinking
    );

    modport slave (
        input  ones_segs, tens_segs, mins_segs, min_tens_segs, timer_done, mag_on,
        output seg_out, digit_en, colon, blinking
    );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit 7-segment driver with mm:ss colon and a
// done-flash sequence. Optional build macro LEADING_ZERO_BLANK_EN blanks
// leading zero minute digits (a zero pattern is 7'h3F).
module seg_display_mux #(
    parameter int REFRESH_DIV = 1000,
    parameter int COLON_DIV   = 500,
    parameter int BLINK_DIV   = 250,
    parameter int BLINKS      = 3
) (
    input  logic          clock,
    input  logic          reset,
    seg_display_if.slave  bus
);

    // Widths are floored at 1 so a divider of 1 still yields a legal vector.
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int COL_W = (COLON_DIV   > 1) ? $clog2(COLON_DIV)   : 1;
    localparam int PH_W  = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
    localparam int FL_W  = (BLINKS      > 1) ? $clog2(BLINKS)      : 1;

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLON_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BLINK_DIV - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(BLINKS - 1);
    localparam logic [6:0]       SEG_ZERO = 7'h3F;

    typedef enum logic [1:0] {IDLE, OFF, ON} state_t;

    state_t           state_q, state_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic             col_ph_q, col_ph_d;
    logic [PH_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [FL_W-1:0]  flash_cnt_q, flash_cnt_d;
    logic             td_dly_q, td_dly_d;
    logic [6:0]       seg_out_q, seg_out_d;
    logic [3:0]       digit_en_q, digit_en_d;
    logic             colon_q, colon_d;
    logic             blinking_q, blinking_d;
    logic             rise;
    logic [6:0]       sel_segs;

    // Next-state logic for the scan, colon and flash FSM plus the registered outputs.
    always_comb begin
        // Digit scan: idx advances once per REFRESH_DIV clocks.
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end

        // Colon: steady on when idle, square wave while the magnetron runs.
        col_cnt_d = '0;
        col_ph_d  = 1'b1;
        if (bus.mag_on) begin
            col_ph_d = col_ph_q;
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                col_ph_d  = ~col_ph_q;
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end

        // Flash sequence on the rising edge of timer_done.
        td_dly_d    = bus.timer_done;
        rise        = bus.timer_done & ~td_dly_q;
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d     = OFF;
                    phase_cnt_d = '0;
                    flash_cnt_d = '0;
                end
            end
            OFF: begin
                if (phase_cnt_q == PH_LAST) begin
                    state_d     = ON;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + PH_W'(1);
                end
            end
            ON: begin
                if (phase_cnt_q == PH_LAST) begin
                    phase_cnt_d = '0;
                    if (flash_cnt_q == FL_LAST) begin
                        state_d     = IDLE;
                        flash_cnt_d = '0;
                    end else begin
                        state_d     = OFF;
                        flash_cnt_d = flash_cnt_q + FL_W'(1);
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping timer_done aborts the flash; it takes priority over a restart.
        if (state_q != IDLE) begin
            if (!bus.timer_done) begin
                state_d     = IDLE;
                phase_cnt_d = '0;
                flash_cnt_d = '0;
            end else if (rise) begin
                state_d     = OFF;
                phase_cnt_d = '0;
                flash_cnt_d = '0;
            end
        end

        // Segment pattern for the slot currently being driven.
        case (idx_q)
            2'd0:    sel_segs = bus.ones_segs;
            2'd1:    sel_segs = bus.tens_segs;
            2'd2:    sel_segs = bus.mins_segs;
            default: sel_segs = bus.min_tens_segs;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd3 && bus.min_tens_segs == SEG_ZERO)
            sel_segs = '0;
        if (idx_q == 2'd2 && bus.min_tens_segs == SEG_ZERO && bus.mins_segs == SEG_ZERO)
            sel_segs = '0;
`endif

        // Outputs follow the next FSM state so they line up with it.
        seg_out_d  = (state_d == OFF) ? 7'd0 : sel_segs;
        digit_en_d = (state_d == OFF) ? 4'd0 : (4'b0001 << idx_q);
        colon_d    = (state_d == OFF) ? 1'b0 : col_ph_d;
        blinking_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            col_cnt_q   <= '0;
            col_ph_q    <= 1'b1;
            phase_cnt_q <= '0;
            flash_cnt_q <= '0;
            td_dly_q    <= 1'b0;
            seg_out_q   <= '0;
            digit_en_q  <= '0;
            colon_q     <= 1'b0;
            blinking_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            col_cnt_q   <= col_cnt_d;
            col_ph_q    <= col_ph_d;
            phase_cnt_q <= phase_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            td_dly_q    <= td_dly_d;
            seg_out_q   <= seg_out_d;
            digit_en_q  <= digit_en_d;
            colon_q     <= colon_d;
            blinking_q  <= blinking_d;
        end
    end

    assign bus.seg_out  = seg_out_q;
    assign bus.digit_en = digit_en_q;
    assign bus.colon    = colon_q;
    assign bus.blinking = blinking_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with small dividers so every scan,
// flash and colon phase is reached within a few dozen clocks.
module tb_seg_display_mux;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    seg_display_if bus();

    seg_display_mux #(
        .REFRESH_DIV(4), .COLON_DIV(3), .BLINK_DIV(2), .BLINKS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0][6:0] in;
        logic [3:0][6:0] plain;
        logic [3:0][6:0] blank;
    } vec_t;

    vec_t vecs[4];
    logic [3:0][6:0] cur_exp;
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic int slot();
        return (cyc / 4) % 4;
    endfunction

    task automatic apply(input vec_t v);
        bus.ones_segs     = v.in[0];
        bus.tens_segs     = v.in[1];
        bus.mins_segs     = v.in[2];
        bus.min_tens_segs = v.in[3];
        cur_exp = BLANK ? v.blank : v.plain;
    endtask

    initial begin
        vecs[0].in    = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        vecs[0].plain = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        vecs[0].blank = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        vecs[1].in    = {7'h3F, 7'h3F, 7'h07, 7'h7D};
        vecs[1].plain = {7'h3F, 7'h3F, 7'h07, 7'h7D};
        vecs[1].blank = {7'h00, 7'h00, 7'h07, 7'h7D};
        vecs[2].in    = {7'h3F, 7'h06, 7'h3F, 7'h3F};
        vecs[2].plain = {7'h3F, 7'h06, 7'h3F, 7'h3F};
        vecs[2].blank = {7'h00, 7'h06, 7'h3F, 7'h3F};
        vecs[3].in    = {7'h06, 7'h6D, 7'h66, 7'h6F};
        vecs[3].plain = {7'h06, 7'h6D, 7'h66, 7'h6F};
        vecs[3].blank = {7'h06, 7'h6D, 7'h66, 7'h6F};

        bus.timer_done = 1'b0;
        bus.mag_on     = 1'b0;
        apply(vecs[0]);

        // Reset held for three edges.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_seg",   bus.seg_out,  0);
        chk("rst_den",   bus.digit_en, 0);
        chk("rst_colon", bus.colon,    0);
        chk("rst_blink", bus.blinking, 0);

        // Release: first edge drives slot 0, then slots step every 4 clocks.
        reset = 1'b0;
        tick();
        cyc = 0;
        chk("rel_den",   bus.digit_en, 4'b0001);
        chk("rel_seg",   bus.seg_out,  7'h3F);
        chk("rel_colon", bus.colon,    1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("scan_den", bus.digit_en, 4'b0001 << slot());
        end

        // Table-driven scan of several digit patterns.
        for (int i = 0; i < 4; i++) begin
            apply(vecs[i]);
            for (int k = 0; k < 16; k++) begin
                tick();
                chk("tbl_den", bus.digit_en, 4'b0001 << slot());
                chk("tbl_seg", bus.seg_out,  cur_exp[slot()]);
                chk("tbl_blk", bus.blinking, 0);
            end
        end

        // Mid-slot change shows on the next edge.
        apply(vecs[0]);
        tick();
        while (slot() != 0) tick();
        tick();
        bus.ones_segs = 7'h7F;
        tick();
        chk("mid_seg", bus.seg_out, 7'h7F);
        apply(vecs[0]);
        tick();

        // Done flash: OFF in clocks 1-2, 5-6, 9-10, blinking for 12 clocks.
        bus.timer_done = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            bit off;
            tick();
            off = (j == 1 || j == 2 || j == 5 || j == 6 || j == 9 || j == 10);
            chk("fl_blink", bus.blinking, (j <= 12) ? 1 : 0);
            chk("fl_den",   bus.digit_en, off ? 4'd0 : (4'b0001 << slot()));
            chk("fl_seg",   bus.seg_out,  off ? 7'd0 : cur_exp[slot()]);
            chk("fl_colon", bus.colon,    off ? 0 : 1);
        end
        bus.timer_done = 1'b0;
        tick();
        tick();

        // Abort three clocks into the flash.
        bus.timer_done = 1'b1;
        tick();
        chk("ab_den1", bus.digit_en, 0);
        tick();
        tick();
        chk("ab_blink3", bus.blinking, 1);
        bus.timer_done = 1'b0;
        tick();
        chk("ab_blink", bus.blinking, 0);
        chk("ab_den",   bus.digit_en, 4'b0001 << slot());
        chk("ab_seg",   bus.seg_out,  cur_exp[slot()]);

        // Colon toggles every 3 clocks while mag_on, back to steady on after.
        bus.mag_on = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("col_run", bus.colon, ((t / 3) % 2 == 0) ? 1 : 0);
        end
        bus.mag_on = 1'b0;
        tick();
        chk("col_stop", bus.colon, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
